vga_timing_param: RTL and testbench
===================================

Name: vga_timing_param

Overview:
- Parametrised VGA timing generator; successor to the fixed 1024x768@65 MHz timing block.
- Horizontal/vertical geometry, sync polarity and counter width are set per instance.
- Adds a pixel-enable input for divided pixel clocks, plus line-start and frame-start strobes.
- Sits at the head of the draw pipeline (background, rect, terrain stages) and drives the hcount/vcount/sync/blank bundle.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, hsync width (pixels)
- H_BP, 160, horizontal back porch (pixels)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BP, 29, vertical back porch (lines)
- HSYNC_POL, 0, 1 = hsync asserted high, 0 = asserted low
- VSYNC_POL, 0, 1 = vsync asserted high, 0 = asserted low
- CNT_W, 11, width of hcount/vcount

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  asynchronous, active-low reset
- pix_en  in  1  advance counters this cycle (tie 1 for full rate)
- hcount  out  CNT_W  current pixel column
- vcount  out  CNT_W  current line
- hblank  out  1  hcount >= H_ACTIVE
- vblank  out  1  vcount >= V_ACTIVE
- hsync  out  1  horizontal sync at HSYNC_POL level
- vsync  out  1  vertical sync at VSYNC_POL level
- line_start  out  1  one-clk strobe on entry to hcount==0
- frame_start  out  1  one-clk strobe on entry to hcount==0, vcount==0

Behaviour:
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 1344.
  - V_TOTAL likewise, default 806.
- Elaboration $error if H_TOTAL or V_TOTAL > 2**CNT_W, or any porch/sync parameter is 0.
- Reset (rst_n low, asynchronous):
  - hcount = 0, vcount = 0.
  - hblank = 0, vblank = 0.
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL.
  - line_start = 0, frame_start = 0.
- Release of rst_n is synchronised by the environment.
- Counting on a rising edge with pix_en = 1:
  - hcount wraps from H_TOTAL-1 to 0, else increments.
  - When hcount wraps, vcount wraps from V_TOTAL-1 to 0, else increments.
  - vcount holds otherwise.
- All outputs are registered and decoded from the next-state counter values, so flags are aligned with the counts on the same cycle. There is zero latency between hcount/vcount and their flags.
- Decode windows:
  - hsync is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule on vcount with V_* parameters.
  - Defaults reproduce hsync 1048..1183 and vsync 771..776.
- pix_en = 0: counters, blank and sync hold.
  - line_start and frame_start return to 0; strobes are exactly one clk wide regardless of pix_en duty.
- line_start = 1 in the clk following the enabled edge that wrapped hcount.
  - frame_start additionally requires the vcount wrap.
  - frame_start implies line_start on the same cycle.
- No strobe is generated on reset exit. The first frame_start occurs after a full frame (H_TOTAL*V_TOTAL enabled cycles).
- Reset mid-frame: immediate return to reset values; no partial strobe.

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN
- Defined:
  - Adds output port frame_cnt (16 bits): count of completed frames.
  - Resets to 0 and increments in the same cycle frame_start asserts.
  - Wraps 16'hFFFF to 0.
- Undefined: port and logic absent; remaining behaviour identical.

Decomposition:
- vga_pkg gains named mode constant sets, each H_/V_ active, FP, SYNC, BP and polarity:
  - MODE_1024x768_* (current defaults)
  - MODE_800x600_* (40 MHz: 800/40/128/88, 600/1/4/23, positive sync)
- Existing HBLANK_*/HSYNC_*/VBLANK_*/VSYNC_* constants are redefined as derived from MODE_1024x768_*.
- Sub-module vga_axis_counter, instantiated twice (H and V):
  - Parameters ACTIVE, FP, SYNC, BP, POL, CNT_W.
  - Inputs inc, plus async reset.
  - Outputs count, blank, sync and wrap carry.
  - H carry drives V inc.

Test Plan:
- Defaults, pix_en=1, two frames:
  - hsync low exactly for hcount 1048..1183.
  - hblank high for 1024..1343.
  - vsync low exactly for vcount 771..776.
  - frame_start every 1344*806 = 1083264 clk.
- 800x600 parameters with positive polarity: hsync high for hcount 840..967; H_TOTAL 1056, V_TOTAL 628; line_start period 1056 clk.
- pix_en toggling 1/0 (half rate):
  - counters advance every 2nd clk.
  - Flags hold during pix_en=0.
  - line_start is one clk wide.
  - Frame period is 2*1083264 clk.
- rst_n asserted at hcount=500, vcount=300:
  - Outputs return to reset values asynchronously, before the next clk edge.
  - After release, first frame_start arrives 1083264 enabled clk later.
- Wrap boundaries:
  - At hcount 1343, vcount 805, next edge gives 0/0 with frame_start=1.
  - At hcount 1343, vcount 10, next edge gives 0/11 with line_start=1, frame_start=0.
- With VGA_TIMING_FRAME_CNT_EN: frame_cnt = 3 after three frames; forced start at 16'hFFFF wraps to 0 with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants -- named mode sets, derived blank/sync
// windows of the reference 1024x768 mode, and a geometry helper.
package vga_pkg;

    function automatic int unsigned axis_total(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync_w,
                                               input int unsigned bp);
        return active + fp + sync_w + bp;
    endfunction

    localparam int unsigned MODE_1024x768_H_ACTIVE  = 1024;
    localparam int unsigned MODE_1024x768_H_FP      = 24;
    localparam int unsigned MODE_1024x768_H_SYNC    = 136;
    localparam int unsigned MODE_1024x768_H_BP      = 160;
    localparam int unsigned MODE_1024x768_V_ACTIVE  = 768;
    localparam int unsigned MODE_1024x768_V_FP      = 3;
    localparam int unsigned MODE_1024x768_V_SYNC    = 6;
    localparam int unsigned MODE_1024x768_V_BP      = 29;
    localparam bit          MODE_1024x768_HSYNC_POL = 1'b0;
    localparam bit          MODE_1024x768_VSYNC_POL = 1'b0;

    localparam int unsigned MODE_800x600_H_ACTIVE   = 800;
    localparam int unsigned MODE_800x600_H_FP       = 40;
    localparam int unsigned MODE_800x600_H_SYNC     = 128;
    localparam int unsigned MODE_800x600_H_BP       = 88;
    localparam int unsigned MODE_800x600_V_ACTIVE   = 600;
    localparam int unsigned MODE_800x600_V_FP       = 1;
    localparam int unsigned MODE_800x600_V_SYNC     = 4;
    localparam int unsigned MODE_800x600_V_BP       = 23;
    localparam bit          MODE_800x600_HSYNC_POL  = 1'b1;
    localparam bit          MODE_800x600_VSYNC_POL  = 1'b1;

    localparam int unsigned H_TOTAL = axis_total(MODE_1024x768_H_ACTIVE, MODE_1024x768_H_FP,
                                                 MODE_1024x768_H_SYNC, MODE_1024x768_H_BP);
    localparam int unsigned V_TOTAL = axis_total(MODE_1024x768_V_ACTIVE, MODE_1024x768_V_FP,
                                                 MODE_1024x768_V_SYNC, MODE_1024x768_V_BP);

    // Inclusive windows, kept for the downstream draw stages.
    localparam int unsigned HBLANK_START = MODE_1024x768_H_ACTIVE;
    localparam int unsigned HBLANK_STOP  = H_TOTAL - 1;
    localparam int unsigned HSYNC_START  = MODE_1024x768_H_ACTIVE + MODE_1024x768_H_FP;
    localparam int unsigned HSYNC_STOP   = HSYNC_START + MODE_1024x768_H_SYNC - 1;
    localparam int unsigned VBLANK_START = MODE_1024x768_V_ACTIVE;
    localparam int unsigned VBLANK_STOP  = V_TOTAL - 1;
    localparam int unsigned VSYNC_START  = MODE_1024x768_V_ACTIVE + MODE_1024x768_V_FP;
    localparam int unsigned VSYNC_STOP   = VSYNC_START + MODE_1024x768_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis. Flags are registered from the next-state
// count so they line up with count; wrap is a combinational carry for the next axis.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = MODE_1024x768_H_ACTIVE,
    parameter int unsigned FP     = MODE_1024x768_H_FP,
    parameter int unsigned SYNC   = MODE_1024x768_H_SYNC,
    parameter int unsigned BP     = MODE_1024x768_H_BP,
    parameter bit          POL    = MODE_1024x768_HSYNC_POL,
    parameter int unsigned CNT_W  = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             blank,
    output logic             sync,
    output logic             wrap
);

    localparam int unsigned      TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] BLANK_BEG = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_BEG  = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(ACTIVE + FP + SYNC);

    if (FP == 0 || SYNC == 0 || BP == 0) begin : g_err_zero
        $error("vga_axis_counter: porch and sync widths must be non-zero");
    end
    if (longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_err_width
        $error("vga_axis_counter: total %0d does not fit in CNT_W=%0d", TOTAL, CNT_W);
    end

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;
    logic             r_blank;
    logic             r_sync;
    logic             w_wrap;

    always_comb begin
        w_wrap = inc && (r_count == LAST);
        w_next = r_count;
        if (w_wrap) begin
            w_next = '0;
        end else if (inc) begin
            w_next = r_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_blank <= 1'b0;
            r_sync  <= ~POL;
        end else begin
            r_count <= w_next;
            r_blank <= (w_next >= BLANK_BEG);
            r_sync  <= ((w_next >= SYNC_BEG) && (w_next < SYNC_END)) ? POL : ~POL;
        end
    end

    assign count = r_count;
    assign blank = r_blank;
    assign sync  = r_sync;
    assign wrap  = w_wrap;

endmodule

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA timing generator with pixel enable and
// line/frame strobes. Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_timing_param
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = MODE_1024x768_H_ACTIVE,
    parameter int unsigned H_FP      = MODE_1024x768_H_FP,
    parameter int unsigned H_SYNC    = MODE_1024x768_H_SYNC,
    parameter int unsigned H_BP      = MODE_1024x768_H_BP,
    parameter int unsigned V_ACTIVE  = MODE_1024x768_V_ACTIVE,
    parameter int unsigned V_FP      = MODE_1024x768_V_FP,
    parameter int unsigned V_SYNC    = MODE_1024x768_V_SYNC,
    parameter int unsigned V_BP      = MODE_1024x768_V_BP,
    parameter bit          HSYNC_POL = MODE_1024x768_HSYNC_POL,
    parameter bit          VSYNC_POL = MODE_1024x768_VSYNC_POL,
    parameter int unsigned CNT_W     = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hblank,
    output logic             vblank,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic             frame_start,
    output logic [15:0]      frame_cnt
`else
    output logic             frame_start
`endif
);

    logic w_h_wrap;
    logic w_v_wrap;
    logic r_line_start;
    logic r_frame_start;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .POL(HSYNC_POL), .CNT_W(CNT_W)
    ) u_h (
        .clk(clk), .rst_n(rst_n), .inc(pix_en),
        .count(hcount), .blank(hblank), .sync(hsync), .wrap(w_h_wrap)
    );

    // Vertical axis advances only on the horizontal carry.
    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .POL(VSYNC_POL), .CNT_W(CNT_W)
    ) u_v (
        .clk(clk), .rst_n(rst_n), .inc(w_h_wrap),
        .count(vcount), .blank(vblank), .sync(vsync), .wrap(w_v_wrap)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_h_wrap;
            r_frame_start <= w_v_wrap;
        end
    end

    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_param.sv
// Scoreboard bench for vga_timing_param: default, 800x600 and a small geometry
// instance; expected strobes and flag edges are queued and checked by monitors.
module tb_vga_timing_param;
    import vga_pkg::*;

    typedef struct { int unsigned t; int unsigned v; bit fs; int unsigned fc; } ls_t;
    typedef struct { int unsigned h; int unsigned v; bit lvl; } tr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pd = 1'b0, ps = 1'b0, pm = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    logic [10:0] d_hc, d_vc, s_hc, s_vc;
    logic [4:0]  m_hc, m_vc;
    logic d_hb, d_vb, d_hs, d_vs, d_ls, d_fs;
    logic s_hb, s_vb, s_hs, s_vs, s_ls, s_fs;
    logic m_hb, m_vb, m_hs, m_vs, m_ls, m_fs;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] d_fc, s_fc, m_fc;
`endif

    vga_timing_param u_def (
        .clk(clk), .rst_n(rst_n), .pix_en(pd), .hcount(d_hc), .vcount(d_vc),
        .hblank(d_hb), .vblank(d_vb), .hsync(d_hs), .vsync(d_vs),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(d_fc),
`endif
        .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_param #(
        .H_ACTIVE(MODE_800x600_H_ACTIVE), .H_FP(MODE_800x600_H_FP),
        .H_SYNC(MODE_800x600_H_SYNC), .H_BP(MODE_800x600_H_BP),
        .V_ACTIVE(MODE_800x600_V_ACTIVE), .V_FP(MODE_800x600_V_FP),
        .V_SYNC(MODE_800x600_V_SYNC), .V_BP(MODE_800x600_V_BP),
        .HSYNC_POL(MODE_800x600_HSYNC_POL), .VSYNC_POL(MODE_800x600_VSYNC_POL),
        .CNT_W(11)
    ) u_sv (
        .clk(clk), .rst_n(rst_n), .pix_en(ps), .hcount(s_hc), .vcount(s_vc),
        .hblank(s_hb), .vblank(s_vb), .hsync(s_hs), .vsync(s_vs),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(s_fc),
`endif
        .line_start(s_ls), .frame_start(s_fs)
    );

    // Small geometry: H_TOTAL 20, V_TOTAL 12, frame = 240 enabled clocks.
    vga_timing_param #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(5),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CNT_W(5)
    ) u_sm (
        .clk(clk), .rst_n(rst_n), .pix_en(pm), .hcount(m_hc), .vcount(m_vc),
        .hblank(m_hb), .vblank(m_vb), .hsync(m_hs), .vsync(m_vs),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(m_fc),
`endif
        .line_start(m_ls), .frame_start(m_fs)
    );

    ls_t q_d_ls[$], q_s_ls[$], q_m_ls[$];
    tr_t q_d_hs[$], q_d_hb[$], q_s_hs[$], q_m_vs[$], q_m_vb[$];

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", n, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string n, int unsigned hc, int unsigned vc);
        checks++;
        errors++;
        $display("FAIL %s unexpected event: got hcount %0d vcount %0d cycle %0d, required none",
                 n, hc, vc, cyc);
    endfunction

    function automatic void cmp_ls(string n, ls_t e, logic ls, logic fs,
                                   int unsigned hc, int unsigned vc);
        chk({n, " line_start"}, 32'(ls), 32'd1);
        chk({n, " frame_start"}, 32'(fs), 32'(e.fs));
        chk({n, " strobe cycle"}, cyc, e.t);
        chk({n, " hcount"}, hc, 32'd0);
        chk({n, " vcount"}, vc, e.v);
    endfunction

    function automatic void cmp_tr(string n, tr_t e, int unsigned hc, int unsigned vc, logic lvl);
        chk({n, " level"}, 32'(lvl), 32'(e.lvl));
        chk({n, " hcount at edge"}, hc, e.h);
        chk({n, " vcount at edge"}, vc, e.v);
    endfunction

    function automatic void chk_rst(string n, int unsigned hc, int unsigned vc, logic hb,
                                    logic vb, logic hs, logic vs, logic ls, logic fs,
                                    logic hs_r, logic vs_r);
        chk({n, " reset hcount"}, hc, 32'd0);
        chk({n, " reset vcount"}, vc, 32'd0);
        chk({n, " reset hblank"}, 32'(hb), 32'd0);
        chk({n, " reset vblank"}, 32'(vb), 32'd0);
        chk({n, " reset hsync"}, 32'(hs), 32'(hs_r));
        chk({n, " reset vsync"}, 32'(vs), 32'(vs_r));
        chk({n, " reset line_start"}, 32'(ls), 32'd0);
        chk({n, " reset frame_start"}, 32'(fs), 32'd0);
    endfunction

    logic d_hs_p = 1'b1, d_hb_p = 1'b0, s_hs_p = 1'b0, m_vs_p = 1'b1, m_vb_p = 1'b0;
    ls_t  m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            d_hs_p <= d_hs;
            d_hb_p <= d_hb;
            s_hs_p <= s_hs;
            m_vs_p <= m_vs;
            m_vb_p <= m_vb;
        end else begin
            if (d_hs !== d_hs_p) begin
                if (q_d_hs.size() == 0) unexpected("def hsync", 32'(d_hc), 32'(d_vc));
                else cmp_tr("def hsync", q_d_hs.pop_front(), 32'(d_hc), 32'(d_vc), d_hs);
            end
            if (d_hb !== d_hb_p) begin
                if (q_d_hb.size() == 0) unexpected("def hblank", 32'(d_hc), 32'(d_vc));
                else cmp_tr("def hblank", q_d_hb.pop_front(), 32'(d_hc), 32'(d_vc), d_hb);
            end
            if (s_hs !== s_hs_p) begin
                if (q_s_hs.size() == 0) unexpected("svga hsync", 32'(s_hc), 32'(s_vc));
                else cmp_tr("svga hsync", q_s_hs.pop_front(), 32'(s_hc), 32'(s_vc), s_hs);
            end
            if (m_vs !== m_vs_p) begin
                if (q_m_vs.size() == 0) unexpected("small vsync", 32'(m_hc), 32'(m_vc));
                else cmp_tr("small vsync", q_m_vs.pop_front(), 32'(m_hc), 32'(m_vc), m_vs);
            end
            if (m_vb !== m_vb_p) begin
                if (q_m_vb.size() == 0) unexpected("small vblank", 32'(m_hc), 32'(m_vc));
                else cmp_tr("small vblank", q_m_vb.pop_front(), 32'(m_hc), 32'(m_vc), m_vb);
            end
            d_hs_p <= d_hs;
            d_hb_p <= d_hb;
            s_hs_p <= s_hs;
            m_vs_p <= m_vs;
            m_vb_p <= m_vb;

            if (d_ls || d_fs) begin
                if (q_d_ls.size() == 0) unexpected("def strobe", 32'(d_hc), 32'(d_vc));
                else cmp_ls("def", q_d_ls.pop_front(), d_ls, d_fs, 32'(d_hc), 32'(d_vc));
            end
            if (s_ls || s_fs) begin
                if (q_s_ls.size() == 0) unexpected("svga strobe", 32'(s_hc), 32'(s_vc));
                else cmp_ls("svga", q_s_ls.pop_front(), s_ls, s_fs, 32'(s_hc), 32'(s_vc));
            end
            if (m_ls || m_fs) begin
                if (q_m_ls.size() == 0) unexpected("small strobe", 32'(m_hc), 32'(m_vc));
                else begin
                    m_e = q_m_ls.pop_front();
                    cmp_ls("small", m_e, m_ls, m_fs, 32'(m_hc), 32'(m_vc));
`ifdef VGA_TIMING_FRAME_CNT_EN
                    chk("small frame_cnt", 32'(m_fc), m_e.fc);
`endif
                end
            end
        end
    end

    task automatic push_small_frame_flags();
        q_m_vb.push_back('{0, 6, 1'b1});
        q_m_vs.push_back('{0, 7, 1'b0});
        q_m_vs.push_back('{0, 9, 1'b1});
        q_m_vb.push_back('{0, 0, 1'b0});
    endtask

    int unsigned base;

    initial begin
        repeat (3) @(negedge clk);
        chk_rst("def", 32'(d_hc), 32'(d_vc), d_hb, d_vb, d_hs, d_vs, d_ls, d_fs, 1'b1, 1'b1);
        chk_rst("svga", 32'(s_hc), 32'(s_vc), s_hb, s_vb, s_hs, s_vs, s_ls, s_fs, 1'b0, 1'b0);
        chk_rst("small", 32'(m_hc), 32'(m_vc), m_hb, m_vb, m_hs, m_vs, m_ls, m_fs, 1'b0, 1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("small reset frame_cnt", 32'(m_fc), 32'd0);
`endif
        rst_n = 1'b1;

        // Default mode, 12 full lines: crosses the vcount 10 -> 11 line wrap.
        base = cyc;
        for (int l = 0; l < 12; l++) begin
            q_d_hb.push_back('{1024, l, 1'b1});
            q_d_hb.push_back('{0, l + 1, 1'b0});
            q_d_hs.push_back('{1048, l, 1'b0});
            q_d_hs.push_back('{1184, l, 1'b1});
            q_d_ls.push_back('{base + 1344 * (l + 1), l + 1, 1'b0, 0});
        end
        pd = 1'b1;
        repeat (16128) @(negedge clk);
        pd = 1'b0;

        // 800x600, positive sync, 3 lines.
        base = cyc;
        for (int l = 0; l < 3; l++) begin
            q_s_hs.push_back('{840, l, 1'b1});
            q_s_hs.push_back('{968, l, 1'b0});
            q_s_ls.push_back('{base + 1056 * (l + 1), l + 1, 1'b0, 0});
        end
        ps = 1'b1;
        repeat (3168) @(negedge clk);
        ps = 1'b0;

        // Small geometry, three full frames at full rate.
        base = cyc;
        for (int k = 1; k <= 36; k++)
            q_m_ls.push_back('{base + 20 * k, k % 12, (k % 12) == 0, k / 12});
        for (int f = 0; f < 3; f++) push_small_frame_flags();
        pm = 1'b1;
        repeat (720) @(negedge clk);
        pm = 1'b0;

        // Half rate: enabled edge n lands on clock base+2n-1.
        base = cyc;
        for (int k = 1; k <= 12; k++)
            q_m_ls.push_back('{base + 40 * k - 1, k % 12, k == 12, (k == 12) ? 4 : 3});
        push_small_frame_flags();
        for (int j = 0; j < 480; j++) begin
            pm = (j % 2 == 0);
            @(negedge clk);
        end
        pm = 1'b0;

        // Mid-frame reset at hcount 7, vcount 4.
        base = cyc;
        for (int k = 1; k <= 4; k++) q_m_ls.push_back('{base + 20 * k, k, 1'b0, 4});
        pm = 1'b1;
        repeat (87) @(negedge clk);
        chk("small hcount before reset", 32'(m_hc), 32'd7);
        chk("small vcount before reset", 32'(m_vc), 32'd4);
        #2 rst_n = 1'b0;
        #1 chk_rst("small async", 32'(m_hc), 32'(m_vc), m_hb, m_vb, m_hs, m_vs, m_ls, m_fs,
                   1'b0, 1'b1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("small async frame_cnt", 32'(m_fc), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc;
        for (int k = 1; k <= 12; k++)
            q_m_ls.push_back('{base + 20 * k, k % 12, k == 12, (k == 12) ? 1 : 0});
        push_small_frame_flags();
        repeat (240) @(negedge clk);
        pm = 1'b0;
        repeat (5) @(negedge clk);

        chk("def line_start leftover", q_d_ls.size(), 32'd0);
        chk("def hsync leftover", q_d_hs.size(), 32'd0);
        chk("def hblank leftover", q_d_hb.size(), 32'd0);
        chk("svga line_start leftover", q_s_ls.size(), 32'd0);
        chk("svga hsync leftover", q_s_hs.size(), 32'd0);
        chk("small line_start leftover", q_m_ls.size(), 32'd0);
        chk("small vsync leftover", q_m_vs.size(), 32'd0);
        chk("small vblank leftover", q_m_vb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
